// File: rtl/nd_1ton_if.sv
// Channel bundle for nd_1ton: one four-phase input channel, NUM_OUT four-phase
// output channels and per-output occupancy status.
interface nd_1ton_if #(
   parameter int NUM_OUT = 4,
   parameter int ASZ     = 8,
   parameter int DSZ     = 8,
   parameter int CW      = 3
);
   logic                   ready;
   logic [ASZ-1:0]         rcv0_src;
   logic [ASZ-1:0]         rcv0_dst;
   logic [DSZ-1:0]         rcv0_dat;
   logic                   rcv0_req;
   logic                   rcv0_ack;
   logic [NUM_OUT*ASZ-1:0] snd_src;
   logic [NUM_OUT*ASZ-1:0] snd_dst;
   logic [NUM_OUT*DSZ-1:0] snd_dat;
   logic [NUM_OUT-1:0]     snd_req;
   logic [NUM_OUT-1:0]     snd_ack;
   logic [NUM_OUT*CW-1:0]  occ;

   // The node itself.
   modport slave (
      output ready,
      input  rcv0_src, rcv0_dst, rcv0_dat, rcv0_req,
      output rcv0_ack,
      output snd_src, snd_dst, snd_dat, snd_req,
      input  snd_ack,
      output occ
   );

   // The surrounding network: drives the input channel, consumes the outputs.
   modport master (
      input  ready,
      output rcv0_src, rcv0_dst, rcv0_dat, rcv0_req,
      input  rcv0_ack,
      input  snd_src, snd_dst, snd_dat, snd_req,
      output snd_ack,
      input  occ
   );
endinterface

// File: rtl/nd_1ton.sv
// One-input, NUM_OUT-output message demultiplexer: routes by destination address
// against ascending bounds into per-output FIFOs, each drained by its own four-phase channel.
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module nd_1ton #(
   parameter int NUM_OUT = 4,
   parameter int BND_1   = 0,
   parameter int BND_2   = 0,
   parameter int BND_3   = 0,
   parameter int FSZ     = `NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ     = `NS_ADDRESS_SIZE,
   parameter int DSZ     = `NS_DATA_SIZE,
   parameter int CW      = $clog2(FSZ) + 1
) (
   input  logic     i_clk,
   input  logic     reset,
   nd_1ton_if.slave bus
);
   localparam int PW = $clog2(FSZ);
   localparam int MW = 2 * ASZ + DSZ;
   localparam logic [ASZ-1:0] BND_1_C = ASZ'(BND_1);
   localparam logic [ASZ-1:0] BND_2_C = ASZ'(BND_2);
   localparam logic [ASZ-1:0] BND_3_C = ASZ'(BND_3);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } out_state_e;

   logic                   ready_q;
   logic [1:0]             init_q;
   logic                   ack_q;
   logic [1:0]             idx_s;
   logic                   sel_full_s;
   logic                   accept_s;
   logic [NUM_OUT-1:0]     full_s;
   logic [NUM_OUT-1:0]     push_s;
   logic [MW-1:0]          msg_s;
   logic [NUM_OUT*ASZ-1:0] snd_src_s;
   logic [NUM_OUT*ASZ-1:0] snd_dst_s;
   logic [NUM_OUT*DSZ-1:0] snd_dat_s;
   logic [NUM_OUT-1:0]     snd_req_s;
   logic [NUM_OUT*CW-1:0]  occ_s;

   assign msg_s = {bus.rcv0_src, bus.rcv0_dst, bus.rcv0_dat};

   // Output index = number of enabled bounds at or below the destination.
   always_comb begin
      idx_s = 2'd0;
      if (bus.rcv0_dst >= BND_1_C) idx_s = idx_s + 2'd1;
      else                         idx_s = idx_s;
      if ((NUM_OUT >= 3) && (bus.rcv0_dst >= BND_2_C)) idx_s = idx_s + 2'd1;
      else                                             idx_s = idx_s;
      if ((NUM_OUT >= 4) && (bus.rcv0_dst >= BND_3_C)) idx_s = idx_s + 2'd1;
      else                                             idx_s = idx_s;
   end

   // Full flag of the target FIFO and the one-hot push strobe.
   always_comb begin
      sel_full_s = 1'b0;
      push_s     = {NUM_OUT{1'b0}};
      for (int k = 0; k < NUM_OUT; k++) begin
         if (idx_s == 2'(k)) begin
            sel_full_s = full_s[k];
            push_s[k]  = accept_s;
         end else begin
            push_s[k]  = 1'b0;
         end
      end
   end

   // Full is sampled before any same-cycle pop, so a full FIFO never takes a push.
   assign accept_s = ready_q && bus.rcv0_req && !ack_q && !sel_full_s;

   // Initialisation sequencing and input four-phase acknowledge.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         init_q  <= 2'd0;
         ack_q   <= 1'b0;
      end else if (!ready_q) begin
         ack_q <= 1'b0;
         if (init_q == 2'd2) ready_q <= 1'b1;
         else                init_q  <= init_q + 2'd1;
      end else if (accept_s) begin
         ack_q <= 1'b1;
      end else if (ack_q && !bus.rcv0_req) begin
         ack_q <= 1'b0;
      end
   end

   generate
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
         logic [MW-1:0] mem_q [FSZ];
         logic [PW-1:0] head_q;
         logic [PW-1:0] tail_q;
         logic [CW-1:0] cnt_q;
         logic [MW-1:0] out_q;
         logic          req_q;
         logic          pop_s;
         out_state_e    state_q;

         assign full_s[k] = (cnt_q == CW'(FSZ));
         assign pop_s     = (state_q == ST_IDLE) && (cnt_q != {CW{1'b0}});

         // FIFO storage write port.
         always_ff @(posedge i_clk) begin
            if (push_s[k]) mem_q[head_q] <= msg_s;
         end

         // FIFO pointers/count and output channel state machine; held clear until ready.
         always_ff @(posedge i_clk) begin
            if (reset || !ready_q) begin
               head_q  <= {PW{1'b0}};
               tail_q  <= {PW{1'b0}};
               cnt_q   <= {CW{1'b0}};
               out_q   <= {MW{1'b0}};
               req_q   <= 1'b0;
               state_q <= ST_IDLE;
            end else begin
               if (push_s[k]) head_q <= head_q + PW'(1);
               if (pop_s)     tail_q <= tail_q + PW'(1);
               cnt_q <= cnt_q + CW'(push_s[k]) - CW'(pop_s);
               case (state_q)
                  ST_IDLE: begin
                     if (pop_s) begin
                        out_q   <= mem_q[tail_q];
                        req_q   <= 1'b1;
                        state_q <= ST_SEND;
                     end
                  end
                  ST_SEND: begin
                     if (bus.snd_ack[k]) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT;
                     end
                  end
                  ST_WAIT: begin
                     if (!bus.snd_ack[k]) state_q <= ST_IDLE;
                  end
                  default: begin
                     req_q   <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               endcase
            end
         end

         assign snd_src_s[k*ASZ +: ASZ] = out_q[MW-1 -: ASZ];
         assign snd_dst_s[k*ASZ +: ASZ] = out_q[DSZ +: ASZ];
         assign snd_dat_s[k*DSZ +: DSZ] = out_q[DSZ-1:0];
         assign snd_req_s[k]            = req_q;
         assign occ_s[k*CW +: CW]       = cnt_q;
      end
   endgenerate

   assign bus.ready    = ready_q;
   assign bus.rcv0_ack = ack_q;
   assign bus.snd_src  = snd_src_s;
   assign bus.snd_dst  = snd_dst_s;
   assign bus.snd_dat  = snd_dat_s;
   assign bus.snd_req  = snd_req_s;
   assign bus.occ      = occ_s;
endmodule

// File: tb/tb_nd_1ton.sv
// Directed bench for nd_1ton: a 4-output node (bounds 4/8/12, depth 4) and a
// 2-output node (bound 0x80, depth 2) exercised scenario by scenario.
module tb_nd_1ton;
   localparam int ASZ = 8;
   localparam int DSZ = 8;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nd_1ton_if #(.NUM_OUT(4), .ASZ(ASZ), .DSZ(DSZ), .CW(3)) ifa ();
   nd_1ton_if #(.NUM_OUT(2), .ASZ(ASZ), .DSZ(DSZ), .CW(2)) ifb ();

   nd_1ton #(.NUM_OUT(4), .BND_1(4), .BND_2(8), .BND_3(12), .FSZ(4), .ASZ(ASZ), .DSZ(DSZ))
      u_a (.i_clk(clk), .reset(reset_a), .bus(ifa.slave));

   nd_1ton #(.NUM_OUT(2), .BND_1(128), .FSZ(2), .ASZ(ASZ), .DSZ(DSZ))
      u_b (.i_clk(clk), .reset(reset_b), .bus(ifb.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] dat, output bit ok);
      ok = 1'b0;
      ifa.rcv0_src = src; ifa.rcv0_dst = dst; ifa.rcv0_dat = dat; ifa.rcv0_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (ifa.rcv0_ack === 1'b1) begin ok = 1'b1; break; end
      end
      ifa.rcv0_req = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 60; i++) begin
            step();
            if (ifa.rcv0_ack === 1'b0) begin ok = 1'b1; break; end
         end
      end
   endtask

   task automatic push_b(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] dat, output bit ok);
      ok = 1'b0;
      ifb.rcv0_src = src; ifb.rcv0_dst = dst; ifb.rcv0_dat = dat; ifb.rcv0_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (ifb.rcv0_ack === 1'b1) begin ok = 1'b1; break; end
      end
      ifb.rcv0_req = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 60; i++) begin
            step();
            if (ifb.rcv0_ack === 1'b0) begin ok = 1'b1; break; end
         end
      end
   endtask

   task automatic test_reset();
      reset_a = 1'b1; reset_b = 1'b1;
      ifa.rcv0_src = 8'h00; ifa.rcv0_dst = 8'h00; ifa.rcv0_dat = 8'h00; ifa.rcv0_req = 1'b0; ifa.snd_ack = 4'b0000;
      ifb.rcv0_src = 8'h00; ifb.rcv0_dst = 8'h00; ifb.rcv0_dat = 8'h00; ifb.rcv0_req = 1'b0; ifb.snd_ack = 2'b00;
      repeat (3) step();
      checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", ifa.ready); end
      checks++; if (ifa.rcv0_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", ifa.rcv0_ack); end
      checks++; if (ifa.snd_req !== 4'b0000) begin failures++; $display("FAIL rst_req got=%b exp=0000", ifa.snd_req); end
      checks++; if (ifa.occ !== 12'h000) begin failures++; $display("FAIL rst_occ got=%h exp=000", ifa.occ); end
      checks++; if ({ifa.snd_src, ifa.snd_dst, ifa.snd_dat} !== 96'h0) begin failures++; $display("FAIL rst_fields got=%h exp=0", {ifa.snd_src, ifa.snd_dst, ifa.snd_dat}); end
      checks++; if (ifb.ready !== 1'b0) begin failures++; $display("FAIL rst_ready_b got=%0b exp=0", ifb.ready); end
      reset_a = 1'b0; reset_b = 1'b0;
      step();
      checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL init_e0 got=%0b exp=0", ifa.ready); end
      step();
      checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL init_e1 got=%0b exp=0", ifa.ready); end
      step();
      checks++; if (ifa.ready !== 1'b1) begin failures++; $display("FAIL init_e2 got=%0b exp=1", ifa.ready); end
      checks++; if (ifb.ready !== 1'b1) begin failures++; $display("FAIL init_e2_b got=%0b exp=1", ifb.ready); end
   endtask

   task automatic test_routing();
      logic [7:0] dsts [8] = '{8'd0, 8'd5, 8'd9, 8'd15, 8'd4, 8'd12, 8'd8, 8'd3};
      int         exps [8] = '{0, 1, 2, 3, 1, 3, 2, 0};
      logic [3:0] exp_req;
      logic [7:0] exp_src;
      logic [7:0] exp_dat;
      for (int j = 0; j < 8; j++) begin
         exp_src = 8'h10 + 8'(j);
         exp_dat = 8'hA0 + 8'(j);
         exp_req = 4'b0001 << exps[j];
         ifa.rcv0_src = exp_src; ifa.rcv0_dst = dsts[j]; ifa.rcv0_dat = exp_dat; ifa.rcv0_req = 1'b1;
         step();
         checks++; if (ifa.rcv0_ack !== 1'b1) begin failures++; $display("FAIL route_ack[%0d] got=%0b exp=1", j, ifa.rcv0_ack); end
         checks++; if (ifa.occ[exps[j]*3 +: 3] !== 3'd1) begin failures++; $display("FAIL route_occ[%0d] got=%0d exp=1", j, ifa.occ[exps[j]*3 +: 3]); end
         checks++; if (ifa.snd_req !== 4'b0000) begin failures++; $display("FAIL route_early_req[%0d] got=%b exp=0000", j, ifa.snd_req); end
         ifa.rcv0_req = 1'b0;
         step();
         checks++; if (ifa.snd_req !== exp_req) begin failures++; $display("FAIL route_req[%0d] got=%b exp=%b", j, ifa.snd_req, exp_req); end
         checks++; if ({ifa.snd_src[exps[j]*8 +: 8], ifa.snd_dst[exps[j]*8 +: 8], ifa.snd_dat[exps[j]*8 +: 8]} !== {exp_src, dsts[j], exp_dat})
            begin failures++; $display("FAIL route_fields[%0d] got=%h exp=%h", j, {ifa.snd_src[exps[j]*8 +: 8], ifa.snd_dst[exps[j]*8 +: 8], ifa.snd_dat[exps[j]*8 +: 8]}, {exp_src, dsts[j], exp_dat}); end
         checks++; if (ifa.rcv0_ack !== 1'b0) begin failures++; $display("FAIL route_ack_clr[%0d] got=%0b exp=0", j, ifa.rcv0_ack); end
         ifa.snd_ack[exps[j]] = 1'b1;
         step();
         checks++; if (ifa.snd_req !== 4'b0000) begin failures++; $display("FAIL route_req_drop[%0d] got=%b exp=0000", j, ifa.snd_req); end
         ifa.snd_ack[exps[j]] = 1'b0;
         step();
      end
   endtask

   task automatic test_backpressure();
      bit         ok;
      bit         ok6;
      bit         all_ok = 1'b1;
      logic [7:0] exp_dat;
      logic [7:0] exp_src;
      ifa.snd_ack = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         push_a(8'h20 + 8'(i), 8'd5, 8'hB0 + 8'(i), ok);
         all_ok &= ok;
      end
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL bp_fill_accept got=%0b exp=1", all_ok); end
      checks++; if (ifa.occ[3 +: 3] !== 3'd4) begin failures++; $display("FAIL bp_occ got=%0d exp=4", ifa.occ[3 +: 3]); end
      checks++; if (ifa.snd_dat[8 +: 8] !== 8'hB0) begin failures++; $display("FAIL bp_head got=%h exp=b0", ifa.snd_dat[8 +: 8]); end
      ifa.rcv0_src = 8'h25; ifa.rcv0_dst = 8'd5; ifa.rcv0_dat = 8'hB5; ifa.rcv0_req = 1'b1;
      repeat (3) step();
      checks++; if (ifa.rcv0_ack !== 1'b0) begin failures++; $display("FAIL bp_stall got=%0b exp=0", ifa.rcv0_ack); end
      fork
         begin
            ok6 = 1'b0;
            for (int i = 0; i < 80; i++) begin
               if (ifa.rcv0_ack === 1'b1) begin ok6 = 1'b1; break; end
               step();
            end
            ifa.rcv0_req = 1'b0;
            for (int i = 0; i < 10 && ifa.rcv0_ack !== 1'b0; i++) step();
         end
         begin
            for (int m = 0; m < 6; m++) begin
               ok = 1'b0;
               for (int i = 0; i < 60; i++) begin
                  if (ifa.snd_req[1] === 1'b1) begin ok = 1'b1; break; end
                  step();
               end
               exp_src = 8'h20 + 8'(m);
               exp_dat = 8'hB0 + 8'(m);
               checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_deliver_timeout[%0d] got=%0b exp=1", m, ok); end
               checks++; if ({ifa.snd_src[8 +: 8], ifa.snd_dat[8 +: 8]} !== {exp_src, exp_dat})
                  begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", m, {ifa.snd_src[8 +: 8], ifa.snd_dat[8 +: 8]}, {exp_src, exp_dat}); end
               ifa.snd_ack[1] = 1'b1;
               for (int i = 0; i < 10; i++) begin
                  step();
                  if (ifa.snd_req[1] === 1'b0) break;
               end
               ifa.snd_ack[1] = 1'b0;
               step();
            end
         end
      join
      checks++; if (ok6 !== 1'b1) begin failures++; $display("FAIL bp_sixth_accept got=%0b exp=1", ok6); end
      checks++; if (ifa.occ !== 12'h000) begin failures++; $display("FAIL bp_drained_occ got=%h exp=000", ifa.occ); end
   endtask

   task automatic test_isolation();
      bit ok;
      bit all_ok = 1'b1;
      ifa.snd_ack = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         push_a(8'h30 + 8'(i), 8'd0, 8'hC0 + 8'(i), ok);
         all_ok &= ok;
      end
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL iso_fill got=%0b exp=1", all_ok); end
      checks++; if (ifa.occ[0 +: 3] !== 3'd4) begin failures++; $display("FAIL iso_occ0 got=%0d exp=4", ifa.occ[0 +: 3]); end
      push_a(8'h3F, 8'd9, 8'hCF, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL iso_accept got=%0b exp=1", ok); end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifa.snd_req[2] === 1'b1) begin ok = 1'b1; break; end
         step();
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL iso_req2 got=%0b exp=1", ok); end
      checks++; if ({ifa.snd_src[16 +: 8], ifa.snd_dat[16 +: 8]} !== 16'h3FCF) begin failures++; $display("FAIL iso_fields got=%h exp=3fcf", {ifa.snd_src[16 +: 8], ifa.snd_dat[16 +: 8]}); end
      ifa.snd_ack[2] = 1'b1;
      step(); step();
      ifa.snd_ack[2] = 1'b0;
      step();
      checks++; if ({ifa.snd_req[0], ifa.occ[0 +: 3], ifa.snd_dat[0 +: 8]} !== {1'b1, 3'd4, 8'hC0})
         begin failures++; $display("FAIL iso_blocked got=%h exp=%h", {ifa.snd_req[0], ifa.occ[0 +: 3], ifa.snd_dat[0 +: 8]}, {1'b1, 3'd4, 8'hC0}); end
   endtask

   task automatic test_reset_midflight();
      bit ok;
      bit stale = 1'b0;
      ifa.snd_ack = 4'b0000;
      for (int i = 0; i < 3; i++) push_a(8'h50 + 8'(i), 8'd15, 8'hD0 + 8'(i), ok);
      checks++; if ({ifa.snd_req[3], ifa.occ[9 +: 3]} !== {1'b1, 3'd2}) begin failures++; $display("FAIL mid_pre got=%h exp=%h", {ifa.snd_req[3], ifa.occ[9 +: 3]}, {1'b1, 3'd2}); end
      reset_a = 1'b1;
      step();
      checks++; if (ifa.snd_req !== 4'b0000) begin failures++; $display("FAIL mid_req got=%b exp=0000", ifa.snd_req); end
      checks++; if (ifa.occ !== 12'h000) begin failures++; $display("FAIL mid_occ got=%h exp=000", ifa.occ); end
      checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", ifa.ready); end
      step();
      reset_a = 1'b0;
      step(); step();
      checks++; if (ifa.ready !== 1'b0) begin failures++; $display("FAIL mid_ready_e1 got=%0b exp=0", ifa.ready); end
      step();
      checks++; if (ifa.ready !== 1'b1) begin failures++; $display("FAIL mid_ready_e2 got=%0b exp=1", ifa.ready); end
      for (int i = 0; i < 12; i++) begin
         step();
         if (ifa.snd_req !== 4'b0000) stale = 1'b1;
      end
      checks++; if (stale !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0b exp=0", stale); end
   endtask

   task automatic test_wrap();
      bit         ok;
      bit         all_ok = 1'b1;
      bit         done = 1'b0;
      logic [1:0] max_occ = 2'd0;
      logic [7:0] exp_dat;
      fork
         begin
            for (int m = 0; m < 10; m++) begin
               push_b(8'h40 + 8'(m), 8'h10, 8'hE0 + 8'(m), ok);
               all_ok &= ok;
            end
         end
         begin
            for (int m = 0; m < 10; m++) begin
               bit got = 1'b0;
               for (int i = 0; i < 60; i++) begin
                  if (ifb.snd_req[0] === 1'b1) begin got = 1'b1; break; end
                  step();
               end
               exp_dat = 8'hE0 + 8'(m);
               checks++; if ({got, ifb.snd_dat[0 +: 8]} !== {1'b1, exp_dat}) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", m, {got, ifb.snd_dat[0 +: 8]}, {1'b1, exp_dat}); end
               ifb.snd_ack[0] = 1'b1;
               for (int i = 0; i < 10; i++) begin
                  step();
                  if (ifb.snd_req[0] === 1'b0) break;
               end
               ifb.snd_ack[0] = 1'b0;
               step();
            end
            done = 1'b1;
         end
         begin
            for (int i = 0; i < 600 && !done; i++) begin
               if (ifb.occ[0 +: 2] > max_occ) max_occ = ifb.occ[0 +: 2];
               step();
            end
         end
      join
      checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL wrap_accept got=%0b exp=1", all_ok); end
      checks++; if (max_occ > 2'd2) begin failures++; $display("FAIL wrap_max_occ got=%0d exp<=2", max_occ); end
   endtask

   task automatic test_boundary();
      logic [7:0] dsts [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
      logic [1:0] exps [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int j = 0; j < 4; j++) begin
         ifb.rcv0_src = 8'h60 + 8'(j); ifb.rcv0_dst = dsts[j]; ifb.rcv0_dat = 8'hF0 + 8'(j); ifb.rcv0_req = 1'b1;
         step();
         ifb.rcv0_req = 1'b0;
         step();
         checks++; if (ifb.snd_req !== exps[j]) begin failures++; $display("FAIL bnd_route[%0d] got=%b exp=%b", j, ifb.snd_req, exps[j]); end
         ifb.snd_ack = exps[j];
         step(); step();
         ifb.snd_ack = 2'b00;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_isolation();
      test_reset_midflight();
      test_wrap();
      test_boundary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
